// File: rtl/execute_stage.sv
// EX stage of the RV32IM pipeline: ALU, branch target, and the EX/MEM register.
// DIV/DIVU/REM/REMU run on an iterative restoring divider that stalls the front end.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic [4:0]  ALUCtrl_pype1,
    input  logic        ALUSrc_pype1,
    input  logic [31:0] read_data1_pype1,
    input  logic [31:0] read_data2_pype1,
    input  logic [31:0] imm_pype1,
    input  logic [31:0] PC_pype1,
    input  logic [31:0] Instraction_pype1,
    input  logic        RegWrite_pype1,
    input  logic [2:0]  MemBranch_pype1,
    input  logic [1:0]  MemtoReg_pype1,
    input  logic [1:0]  MemRW_pype1,
    input  logic [1:0]  dsize_pype1,
    input  logic [1:0]  ID_EX_write_addi_pype1,
    input  logic [4:0]  WReg_pype1,
    output logic        RegWrite_pype2,
    output logic [2:0]  MemBranch_pype2,
    output logic [1:0]  MemtoReg_pype2,
    output logic [1:0]  MemRW_pype2,
    output logic [1:0]  dsize_pype2,
    output logic [1:0]  ID_EX_write_addi_pype2,
    output logic [4:0]  WReg_pype2,
    output logic [31:0] ALU_co_pype,
    output logic [31:0] PCBranch_pype2,
    output logic [31:0] PCp4_pype2,
    output logic [31:0] read_data2_pype2,
    output logic [31:0] Instraction_pype2,
    output logic        ex_stall
);

    // Branch-type encoding shared with mem_access; JALR needs bit 0 of the target cleared.
    localparam logic [2:0] BR_JALR = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    div_state_t  state_r;
    logic [5:0]  cnt_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] dvs_r;
    logic [31:0] dividend_r;
    logic        quo_neg_r;
    logic        rem_neg_r;
    logic        is_rem_r;
    logic        div_zero_r;

    logic [31:0] a_s;
    logic [31:0] b_s;
    logic [31:0] a_abs_s;
    logic [31:0] b_abs_s;
    logic        div_op_s;
    logic        div_signed_s;
    logic        div_rem_s;
    logic [32:0] trial_s;
    logic [31:0] div_res_s;
    logic [31:0] alu_res_s;
    logic [31:0] alu_final_s;
    logic        ex_stall_s;

    assign a_s          = read_data1_pype1;
    assign b_s          = ALUSrc_pype1 ? imm_pype1 : read_data2_pype1;
    assign div_op_s     = (ALUCtrl_pype1 == 5'd14) || (ALUCtrl_pype1 == 5'd15) ||
                          (ALUCtrl_pype1 == 5'd16) || (ALUCtrl_pype1 == 5'd17);
    assign div_signed_s = (ALUCtrl_pype1 == 5'd14) || (ALUCtrl_pype1 == 5'd16);
    assign div_rem_s    = (ALUCtrl_pype1 == 5'd16) || (ALUCtrl_pype1 == 5'd17);
    assign a_abs_s      = (div_signed_s && a_s[31]) ? (~a_s + 32'd1) : a_s;
    assign b_abs_s      = (div_signed_s && b_s[31]) ? (~b_s + 32'd1) : b_s;
    assign trial_s      = {rem_r, quo_r[31]} - {1'b0, dvs_r};

    // Stall is forced low while reset is asserted so the front end is never frozen by X/reset.
    assign ex_stall_s = rst && div_op_s && ((state_r == IDLE) || (state_r == RUN));
    assign ex_stall   = ex_stall_s;

    // Final divider result: sign correction, with divide-by-zero handled explicitly.
    always_comb begin
        div_res_s = 32'd0;
        if (div_zero_r) begin
            if (is_rem_r) begin
                div_res_s = dividend_r;
            end else begin
                div_res_s = 32'hFFFF_FFFF;
            end
        end else if (is_rem_r) begin
            div_res_s = rem_neg_r ? (~rem_r + 32'd1) : rem_r;
        end else begin
            div_res_s = quo_neg_r ? (~quo_r + 32'd1) : quo_r;
        end
    end

    // ALU operation select; div-class ops return the divider result (only loaded in DONE).
    always_comb begin
        alu_res_s = 32'd0;
        case (ALUCtrl_pype1)
            5'd0:    alu_res_s = a_s + b_s;
            5'd1:    alu_res_s = a_s - b_s;
            5'd2:    alu_res_s = a_s << b_s[4:0];
            5'd3:    alu_res_s = {31'd0, ($signed(a_s) < $signed(b_s))};
            5'd4:    alu_res_s = {31'd0, (a_s < b_s)};
            5'd5:    alu_res_s = a_s ^ b_s;
            5'd6:    alu_res_s = a_s >> b_s[4:0];
            5'd7:    alu_res_s = $signed(a_s) >>> b_s[4:0];
            5'd8:    alu_res_s = a_s | b_s;
            5'd9:    alu_res_s = a_s & b_s;
            5'd10:   alu_res_s = a_s * b_s;
            5'd14,
            5'd15,
            5'd16,
            5'd17:   alu_res_s = div_res_s;
            default: alu_res_s = 32'd0;
        endcase
    end

    // JALR target alignment.
    always_comb begin
        alu_final_s = alu_res_s;
        if (MemBranch_pype1 == BR_JALR) begin
            alu_final_s = {alu_res_s[31:1], 1'b0};
        end else begin
            alu_final_s = alu_res_s;
        end
    end

    // Divider FSM: operands are latched as magnitudes, one restoring step per RUN cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            cnt_r      <= 6'd0;
            quo_r      <= 32'd0;
            rem_r      <= 32'd0;
            dvs_r      <= 32'd0;
            dividend_r <= 32'd0;
            quo_neg_r  <= 1'b0;
            rem_neg_r  <= 1'b0;
            is_rem_r   <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (keep) begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
        end else if (nop) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (div_op_s) begin
                        state_r    <= RUN;
                        cnt_r      <= 6'd0;
                        quo_r      <= a_abs_s;
                        rem_r      <= 32'd0;
                        dvs_r      <= b_abs_s;
                        dividend_r <= a_s;
                        quo_neg_r  <= div_signed_s && (a_s[31] ^ b_s[31]);
                        rem_neg_r  <= div_signed_s && a_s[31];
                        is_rem_r   <= div_rem_s;
                        div_zero_r <= (b_s == 32'd0);
                    end
                end
                RUN: begin
                    if (!trial_s[32]) begin
                        rem_r <= trial_s[31:0];
                        quo_r <= {quo_r[30:0], 1'b1};
                    end else begin
                        rem_r <= {rem_r[30:0], quo_r[31]};
                        quo_r <= {quo_r[30:0], 1'b0};
                    end
                    cnt_r <= cnt_r + 6'd1;
                    if (cnt_r == 6'd31) begin
                        state_r <= DONE;
                    end
                end
                DONE:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // EX/MEM register: hold on keep, bubble on flush or stall, otherwise load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite_pype2         <= 1'b0;
            MemBranch_pype2        <= 3'd0;
            MemtoReg_pype2         <= 2'd0;
            MemRW_pype2            <= 2'd0;
            dsize_pype2            <= 2'd0;
            ID_EX_write_addi_pype2 <= 2'd0;
            WReg_pype2             <= 5'd0;
            ALU_co_pype            <= 32'd0;
            PCBranch_pype2         <= 32'd0;
            PCp4_pype2             <= 32'd0;
            read_data2_pype2       <= 32'd0;
            Instraction_pype2      <= 32'd0;
        end else if (!keep) begin
            if (nop || ex_stall_s) begin
                RegWrite_pype2         <= 1'b0;
                MemBranch_pype2        <= 3'd0;
                MemtoReg_pype2         <= 2'd0;
                MemRW_pype2            <= 2'd0;
                dsize_pype2            <= 2'd0;
                ID_EX_write_addi_pype2 <= 2'd0;
                WReg_pype2             <= 5'd0;
                ALU_co_pype            <= 32'd0;
                PCBranch_pype2         <= 32'd0;
                PCp4_pype2             <= 32'd0;
                read_data2_pype2       <= 32'd0;
                Instraction_pype2      <= 32'd0;
            end else begin
                RegWrite_pype2         <= RegWrite_pype1;
                MemBranch_pype2        <= MemBranch_pype1;
                MemtoReg_pype2         <= MemtoReg_pype1;
                MemRW_pype2            <= MemRW_pype1;
                dsize_pype2            <= dsize_pype1;
                ID_EX_write_addi_pype2 <= ID_EX_write_addi_pype1;
                WReg_pype2             <= WReg_pype1;
                ALU_co_pype            <= alu_final_s;
                PCBranch_pype2         <= PC_pype1 + imm_pype1;
                PCp4_pype2             <= PC_pype1 + 32'd4;
                read_data2_pype2       <= read_data2_pype1;
                Instraction_pype2      <= Instraction_pype1;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage: ALU ops, branch targets,
// divider latency/bubbles/special cases, flush, reset and hold behaviour.
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        keep;
    logic        nop;
    logic [4:0]  ALUCtrl_pype1;
    logic        ALUSrc_pype1;
    logic [31:0] read_data1_pype1;
    logic [31:0] read_data2_pype1;
    logic [31:0] imm_pype1;
    logic [31:0] PC_pype1;
    logic [31:0] Instraction_pype1;
    logic        RegWrite_pype1;
    logic [2:0]  MemBranch_pype1;
    logic [1:0]  MemtoReg_pype1;
    logic [1:0]  MemRW_pype1;
    logic [1:0]  dsize_pype1;
    logic [1:0]  ID_EX_write_addi_pype1;
    logic [4:0]  WReg_pype1;
    logic        RegWrite_pype2;
    logic [2:0]  MemBranch_pype2;
    logic [1:0]  MemtoReg_pype2;
    logic [1:0]  MemRW_pype2;
    logic [1:0]  dsize_pype2;
    logic [1:0]  ID_EX_write_addi_pype2;
    logic [4:0]  WReg_pype2;
    logic [31:0] ALU_co_pype;
    logic [31:0] PCBranch_pype2;
    logic [31:0] PCp4_pype2;
    logic [31:0] read_data2_pype2;
    logic [31:0] Instraction_pype2;
    logic        ex_stall;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] BR_JALR = 3'd6;

    logic [176:0] all_out_s;
    assign all_out_s = {RegWrite_pype2, MemBranch_pype2, MemtoReg_pype2, MemRW_pype2,
                        dsize_pype2, ID_EX_write_addi_pype2, WReg_pype2, ALU_co_pype,
                        PCBranch_pype2, PCp4_pype2, read_data2_pype2, Instraction_pype2};

    execute_stage dut (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop),
        .ALUCtrl_pype1(ALUCtrl_pype1), .ALUSrc_pype1(ALUSrc_pype1),
        .read_data1_pype1(read_data1_pype1), .read_data2_pype1(read_data2_pype1),
        .imm_pype1(imm_pype1), .PC_pype1(PC_pype1), .Instraction_pype1(Instraction_pype1),
        .RegWrite_pype1(RegWrite_pype1), .MemBranch_pype1(MemBranch_pype1),
        .MemtoReg_pype1(MemtoReg_pype1), .MemRW_pype1(MemRW_pype1),
        .dsize_pype1(dsize_pype1), .ID_EX_write_addi_pype1(ID_EX_write_addi_pype1),
        .WReg_pype1(WReg_pype1),
        .RegWrite_pype2(RegWrite_pype2), .MemBranch_pype2(MemBranch_pype2),
        .MemtoReg_pype2(MemtoReg_pype2), .MemRW_pype2(MemRW_pype2),
        .dsize_pype2(dsize_pype2), .ID_EX_write_addi_pype2(ID_EX_write_addi_pype2),
        .WReg_pype2(WReg_pype2), .ALU_co_pype(ALU_co_pype),
        .PCBranch_pype2(PCBranch_pype2), .PCp4_pype2(PCp4_pype2),
        .read_data2_pype2(read_data2_pype2), .Instraction_pype2(Instraction_pype2),
        .ex_stall(ex_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        keep = 1'b0; nop = 1'b0;
        ALUCtrl_pype1 = 5'd0; ALUSrc_pype1 = 1'b0;
        read_data1_pype1 = 32'd0; read_data2_pype1 = 32'd0; imm_pype1 = 32'd0;
        PC_pype1 = 32'd0; Instraction_pype1 = 32'd0;
        RegWrite_pype1 = 1'b0; MemBranch_pype1 = 3'd0; MemtoReg_pype1 = 2'd0;
        MemRW_pype1 = 2'd0; dsize_pype1 = 2'd0; ID_EX_write_addi_pype1 = 2'd0;
        WReg_pype1 = 5'd0;
    endtask

    task automatic drive(input logic [4:0] ctrl, input logic [31:0] a, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic src, input logic [2:0] mb,
                         input logic [31:0] pc);
        ALUCtrl_pype1 = ctrl; read_data1_pype1 = a; read_data2_pype1 = rs2;
        imm_pype1 = imm; ALUSrc_pype1 = src; MemBranch_pype1 = mb; PC_pype1 = pc;
        RegWrite_pype1 = 1'b1; MemRW_pype1 = 2'd1; WReg_pype1 = 5'd5;
    endtask

    task automatic test_reset();
        set_idle();
        ALUCtrl_pype1 = 5'd14;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b want 0", ex_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (all_out_s !== 177'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", all_out_s);
        end
        set_idle();
        rst = 1'b1;
    endtask

    logic [4:0]  t_ctrl [0:12] = '{5'd0, 5'd7, 5'd4, 5'd3, 5'd3, 5'd1, 5'd2, 5'd6,
                                   5'd5, 5'd8, 5'd9, 5'd10, 5'd11};
    logic [31:0] t_a    [0:12] = '{32'h7FFFFFFF, 32'h80000000, 32'h1, 32'hFFFFFFFF, 32'h1,
                                   32'h5, 32'h1, 32'h80000000, 32'hF0F0F0F0, 32'h0F,
                                   32'hFF00, 32'hFFFFFFFF, 32'h5};
    logic [31:0] t_b    [0:12] = '{32'hDEAD, 32'h4, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF,
                                   32'h5, 32'h21, 32'h4, 32'hFF00FF00, 32'hF0,
                                   32'h0FF0, 32'h3, 32'h6};
    logic [31:0] t_exp  [0:12] = '{32'h80000000, 32'hF8000000, 32'h1, 32'h1, 32'h0,
                                   32'h0, 32'h2, 32'h08000000, 32'h0FF00FF0, 32'hFF,
                                   32'h0F00, 32'hFFFFFFFD, 32'h0};

    task automatic test_alu();
        for (int i = 0; i < 13; i++) begin
            // Vector 0 takes operand B from the immediate (1) instead of rs2.
            drive(t_ctrl[i], t_a[i], t_b[i], 32'd1, (i == 0), 3'd0, 32'd0);
            @(posedge clk); #1;
            checks++;
            if (ALU_co_pype !== t_exp[i]) begin
                errors++; $display("FAIL alu_vec%0d: got %h want %h", i, ALU_co_pype, t_exp[i]);
            end
        end
        set_idle();
    endtask

    task automatic test_branch();
        drive(5'd0, 32'h1001, 32'd0, 32'd2, 1'b1, BR_JALR, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (ALU_co_pype !== 32'h1002) begin
            errors++; $display("FAIL jalr_target: got %h want 00001002", ALU_co_pype);
        end
        drive(5'd0, 32'h1001, 32'd0, 32'd2, 1'b1, 3'd0, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (ALU_co_pype !== 32'h1003) begin
            errors++; $display("FAIL nonjalr_bit0: got %h want 00001003", ALU_co_pype);
        end
        drive(5'd1, 32'd9, 32'd9, 32'hFFFFFFF8, 1'b0, 3'd1, 32'h100);
        @(posedge clk); #1;
        checks++;
        if (PCBranch_pype2 !== 32'hF8) begin
            errors++; $display("FAIL pc_branch: got %h want 000000f8", PCBranch_pype2);
        end
        checks++;
        if (PCp4_pype2 !== 32'h104) begin
            errors++; $display("FAIL pc_plus4: got %h want 00000104", PCp4_pype2);
        end
        checks++;
        if (ALU_co_pype !== 32'h0) begin
            errors++; $display("FAIL beq_compare: got %h want 0", ALU_co_pype);
        end
        drive(5'd0, 32'd0, 32'd0, 32'h8, 1'b0, 3'd0, 32'hFFFFFFFC);
        @(posedge clk); #1;
        checks++;
        if ({PCp4_pype2, PCBranch_pype2} !== {32'h0, 32'h4}) begin
            errors++; $display("FAIL pc_wrap: got %h/%h want 0/4", PCp4_pype2, PCBranch_pype2);
        end
        set_idle();
    endtask

    // Presents a div op and measures stall cycles, bubbles and result latency.
    task automatic run_div(input string name, input logic [4:0] ctrl, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res,
                           input int kstart, input int klen,
                           input int exp_edges, input int exp_stalls);
        int  edges = 0;
        int  stalls = 0;
        int  bubbles = 0;
        bit  done = 0;
        bit  stalled;
        drive(ctrl, a, b, 32'd0, 1'b0, 3'd0, 32'h40);
        while (!done && edges < 60) begin
            keep = (edges >= kstart) && (edges < kstart + klen);
            #1 stalled = ex_stall;
            if (stalled) stalls++;
            @(posedge clk); #1;
            edges++;
            if (stalled || keep) begin
                if (RegWrite_pype2 === 1'b0 && MemRW_pype2 === 2'd0 && ALU_co_pype === 32'd0)
                    bubbles++;
            end else begin
                done = 1;
            end
        end
        keep = 1'b0;
        checks++;
        if (!done) begin
            errors++; $display("FAIL %s_timeout: no result within %0d edges", name, edges);
        end
        checks++;
        if (edges != exp_edges) begin
            errors++; $display("FAIL %s_latency: got %0d edges want %0d", name, edges, exp_edges);
        end
        checks++;
        if (stalls != exp_stalls) begin
            errors++; $display("FAIL %s_stall: got %0d cycles want %0d", name, stalls, exp_stalls);
        end
        checks++;
        if (bubbles != exp_edges - 1) begin
            errors++; $display("FAIL %s_bubbles: got %0d want %0d", name, bubbles, exp_edges - 1);
        end
        checks++;
        if (ALU_co_pype !== exp_res || RegWrite_pype2 !== 1'b1) begin
            errors++; $display("FAIL %s_result: got %h rw=%b want %h rw=1", name, ALU_co_pype,
                               RegWrite_pype2, exp_res);
        end
        set_idle();
    endtask

    task automatic test_div();
        run_div("div_neg",   5'd14, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, -1, 0, 34, 33);
        run_div("rem_neg",   5'd16, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, -1, 0, 34, 33);
        run_div("divu_zero", 5'd15, 32'h1234, 32'd0, 32'hFFFFFFFF, -1, 0, 34, 33);
        run_div("remu_zero", 5'd17, 32'd5, 32'd0, 32'd5, -1, 0, 34, 33);
        run_div("div_ovf",   5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, -1, 0, 34, 33);
        run_div("rem_ovf",   5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h0, -1, 0, 34, 33);
        run_div("div_zero",  5'd14, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, -1, 0, 34, 33);
        run_div("rem_zero",  5'd16, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, -1, 0, 34, 33);
    endtask

    task automatic test_back_to_back();
        run_div("b2b_divu", 5'd15, 32'd100, 32'd7, 32'd14, -1, 0, 34, 33);
        run_div("b2b_remu", 5'd17, 32'd100, 32'd7, 32'd2, -1, 0, 34, 33);
    endtask

    task automatic test_nop();
        drive(5'd14, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 3'd0, 32'h40);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (ex_stall !== 1'b1) begin
            errors++; $display("FAIL nop_pre_stall: got %b want 1", ex_stall);
        end
        nop = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (all_out_s !== 177'd0) begin
            errors++; $display("FAIL nop_bubble: got %h want 0", all_out_s);
        end
        nop = 1'b0;
        drive(5'd0, 32'd3, 32'd4, 32'd0, 1'b0, 3'd0, 32'h0);
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++; $display("FAIL nop_stall_drop: got %b want 0", ex_stall);
        end
        @(posedge clk); #1;
        checks++;
        if (ALU_co_pype !== 32'd7) begin
            errors++; $display("FAIL nop_no_result: got %h want 00000007", ALU_co_pype);
        end
        set_idle();
    endtask

    task automatic test_reset_mid();
        drive(5'd14, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 3'd0, 32'h40);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ex_stall !== 1'b0 || all_out_s !== 177'd0) begin
            errors++; $display("FAIL rst_mid: stall=%b out=%h want 0/0", ex_stall, all_out_s);
        end
        set_idle();
        @(posedge clk); #1;
        rst = 1'b1;
        run_div("post_rst", 5'd15, 32'd100, 32'd7, 32'd14, -1, 0, 34, 33);
    endtask

    task automatic test_keep();
        logic [176:0] exp_v;
        exp_v = {1'b1, 3'd2, 2'd1, 2'd2, 2'd3, 2'd1, 5'd17, 32'h30, 32'h240, 32'h204,
                 32'h20, 32'hDEADBEEF};
        ALUCtrl_pype1 = 5'd0; ALUSrc_pype1 = 1'b0;
        read_data1_pype1 = 32'h10; read_data2_pype1 = 32'h20; imm_pype1 = 32'h40;
        PC_pype1 = 32'h200; Instraction_pype1 = 32'hDEADBEEF;
        RegWrite_pype1 = 1'b1; MemBranch_pype1 = 3'd2; MemtoReg_pype1 = 2'd1;
        MemRW_pype1 = 2'd2; dsize_pype1 = 2'd3; ID_EX_write_addi_pype1 = 2'd1; WReg_pype1 = 5'd17;
        @(posedge clk); #1;
        checks++;
        if (all_out_s !== exp_v) begin
            errors++; $display("FAIL keep_load: got %h want %h", all_out_s, exp_v);
        end
        set_idle();
        read_data1_pype1 = 32'h55; PC_pype1 = 32'h900; Instraction_pype1 = 32'h1;
        keep = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (all_out_s !== exp_v) begin
                errors++; $display("FAIL keep_hold%0d: got %h want %h", i, all_out_s, exp_v);
            end
        end
        set_idle();
        run_div("keep_run",  5'd14, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 5, 3, 37, 36);
        run_div("keep_done", 5'd15, 32'd100, 32'd7, 32'd14, 33, 2, 36, 33);
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_alu();
        test_branch();
        test_div();
        test_back_to_back();
        test_nop();
        test_reset_mid();
        test_keep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
